apb_spi_nor_ctrl: RTL

//  APB3 slave that runs single SPI NOR flash commands over a bit-serial, mode-0 SPI master.

---
 rtl/apb_spi_nor_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_spi_nor_ctrl.sv
// APB3 slave issuing single SPI NOR commands through a mode-0, bit-serial SPI master.
// Register file, opcode decode, phase sequencer and shift datapath in one block.
module apb_spi_nor_ctrl #(
    parameter int unsigned ADDR_BYTES = 3,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic        p_clk,
    input  logic        p_reset,
    input  logic [31:0] p_addr,
    input  logic        p_write,
    input  logic        p_sel_x,
    input  logic        p_enable,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_ready,
    output logic        p_slverr,
    output logic        s_clk,
    output logic        s_css,
    output logic        s_mosi,
    input  logic        s_miso,
    output logic        irq
);

    localparam int unsigned AW   = 8 * ADDR_BYTES;
    localparam int unsigned DW   = 8 * DATA_BYTES;
    localparam int unsigned TXW  = 8 + AW + DW;
    localparam int unsigned BCW  = $clog2(TXW + 1);
    localparam int unsigned DIVW = $clog2(CLK_DIV + 1);
    localparam int unsigned GAPW = $clog2(CS_GAP + 2);

    typedef enum logic [2:0] {IDLE, SETUP, OPC, ADDR, DATA, HOLD} state_t;

    state_t            state, state_nx;
    logic [7:0]        cmd_q;
    logic [AW-1:0]     addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              done_q, err_q, ie_q;
    logic [TXW-1:0]    tx_sr;
    logic [31:0]       rx_sr;
    logic [BCW-1:0]    bit_cnt, bit_load, data_bits;
    logic [DIVW-1:0]   div_cnt;
    logic [GAPW-1:0]   gap_cnt;
    logic [7:0]        op;
    logic              access, wr, cmd_wr, busy, start;
    logic              dec_valid, has_addr, is_read, is_pp;
    logic              tick, rise, fall;
    logic [2:0]        reg_sel;
    logic              unused;

    assign access   = p_sel_x & p_enable;
    assign wr       = access & p_write;
    assign reg_sel  = p_addr[4:2];
    assign cmd_wr   = wr && (reg_sel == 3'd0);
    assign busy     = (state != IDLE);
    assign start    = cmd_wr && !busy && dec_valid;
    assign tick     = (div_cnt == '0);
    assign rise     = tick && !s_clk;
    assign fall     = tick && s_clk;
    assign p_ready  = 1'b1;
    assign p_slverr = cmd_wr && busy;
    assign irq      = done_q & ie_q;
    assign unused   = ^{p_addr[31:5], p_addr[1:0]};

    // Decode the incoming opcode while idle, the latched one during a transfer.
    always_comb begin
        op        = (state == IDLE) ? p_wdata[7:0] : cmd_q;
        dec_valid = 1'b1;
        has_addr  = 1'b0;
        data_bits = '0;
        is_read   = 1'b0;
        is_pp     = 1'b0;
        case (op)
            8'h06, 8'h04: ;
            8'h05: begin data_bits = BCW'(8); is_read = 1'b1; end
            8'h03: begin has_addr = 1'b1; data_bits = BCW'(DW); is_read = 1'b1; end
            8'h02: begin has_addr = 1'b1; data_bits = BCW'(DW); is_pp = 1'b1; end
            8'h20, 8'hD8: has_addr = 1'b1;
            default: dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        bit_load = '0;
        case (state)
            IDLE:  if (start) state_nx = SETUP;
            SETUP: if (gap_cnt == '0) state_nx = OPC;
            OPC:   if (fall && bit_cnt == '0)
                       state_nx = has_addr ? ADDR : ((data_bits != '0) ? DATA : HOLD);
            ADDR:  if (fall && bit_cnt == '0)
                       state_nx = (data_bits != '0) ? DATA : HOLD;
            DATA:  if (fall && bit_cnt == '0) state_nx = HOLD;
            HOLD:  if (gap_cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state_nx == ADDR)
            bit_load = BCW'(AW - 1);
        else if (state_nx == DATA)
            bit_load = data_bits - BCW'(1);
    end

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ie_q    <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            s_clk   <= 1'b0;
            s_css   <= 1'b1;
            s_mosi  <= 1'b0;
        end else begin
            if (wr) begin
                case (reg_sel)
                    3'd0: if (!busy) cmd_q <= p_wdata[7:0];
                    3'd1: addr_q  <= p_wdata[AW-1:0];
                    3'd2: wdata_q <= p_wdata;
                    3'd4: begin
                        if (p_wdata[1]) done_q <= 1'b0;
                        if (p_wdata[2]) err_q  <= 1'b0;
                    end
                    3'd5: ie_q <= p_wdata[0];
                    default: ;
                endcase
            end
            // Status sets follow the W1C clears so a same-edge set wins.
            if (cmd_wr) begin
                if (busy) begin
                    err_q <= 1'b1;
                end else if (!dec_valid) begin
                    err_q  <= 1'b1;
                    done_q <= 1'b1;
                end
            end
            if (start) begin
                done_q  <= 1'b0;
                tx_sr   <= {p_wdata[7:0], addr_q, is_pp ? wdata_q[DW-1:0] : DW'(0)};
                rx_sr   <= '0;
                gap_cnt <= GAPW'(CS_GAP);
                bit_cnt <= BCW'(7);
            end
            case (state)
                SETUP: begin
                    s_css <= 1'b0;
                    if (gap_cnt == '0) begin
                        s_mosi  <= tx_sr[TXW-1];
                        tx_sr   <= {tx_sr[TXW-2:0], 1'b0};
                        div_cnt <= DIVW'(CLK_DIV - 1);
                    end else begin
                        gap_cnt <= gap_cnt - GAPW'(1);
                    end
                end
                OPC, ADDR, DATA: begin
                    if (tick) begin
                        div_cnt <= DIVW'(CLK_DIV - 1);
                        s_clk   <= ~s_clk;
                    end else begin
                        div_cnt <= div_cnt - DIVW'(1);
                    end
                    if (rise && state == DATA)
                        rx_sr <= {rx_sr[30:0], s_miso};
                    if (fall) begin
                        bit_cnt <= (bit_cnt == '0) ? bit_load : bit_cnt - BCW'(1);
                        if (state_nx == HOLD) begin
                            s_mosi  <= 1'b0;
                            gap_cnt <= GAPW'(CS_GAP - 1);
                            if (is_read) rdata_q <= rx_sr;
                        end else begin
                            s_mosi <= tx_sr[TXW-1];
                            tx_sr  <= {tx_sr[TXW-2:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (gap_cnt == '0) begin
                        s_css  <= 1'b1;
                        done_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAPW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        p_rdata = '0;
        case (reg_sel)
            3'd0: p_rdata[7:0]    = cmd_q;
            3'd1: p_rdata[AW-1:0] = addr_q;
            3'd2: p_rdata         = wdata_q;
            3'd3: p_rdata         = rdata_q;
            3'd4: p_rdata[2:0]    = {err_q, done_q, busy};
            3'd5: p_rdata[0]      = ie_q;
            default: ;
        endcase
    end

endmodule
